// File: rtl/uart_regwr_if.sv
// Register write port: address, data and a one-cycle strobe, driven by the
// frame parser and sunk by register consumers.
interface uart_regwr_if;
    logic [7:0] regaddr;
    logic [7:0] regdata;
    logic       regvalid;

    modport master (output regaddr, output regdata, output regvalid);
    modport slave  (input  regaddr, input  regdata, input  regvalid);
endinterface

// File: rtl/uart_regwr.sv
// 8N1 UART receiver plus a sync/address/data frame parser that issues one
// register write strobe per completed frame.
module uart_regwr #(
    parameter int unsigned CLKDIV = 434,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rx,
    uart_regwr_if.master  wr,
    output logic          err
);

    localparam logic [15:0] HALF_BIT = 16'(CLKDIV / 2 - 1);
    localparam logic [15:0] FULL_BIT = 16'(CLKDIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_st_t;
    typedef enum logic [1:0] {P_SYNC, P_ADDR, P_DATA} par_st_t;

    bit_st_t     bst_q;
    par_st_t     pst_q;
    logic        rx_meta_q, rx_sync_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        bstb_q;
    logic        err_q;
    logic        wait_hi_q;
    logic [7:0]  addr_hold_q;
    logic [7:0]  regaddr_q, regdata_q;
    logic        regvalid_q;

    logic cnt_zero;
    assign cnt_zero = (cnt_q == 16'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            bst_q       <= IDLE;
            pst_q       <= P_SYNC;
            cnt_q       <= 16'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            bstb_q      <= 1'b0;
            err_q       <= 1'b0;
            wait_hi_q   <= 1'b0;
            addr_hold_q <= 8'd0;
            regaddr_q   <= 8'd0;
            regdata_q   <= 8'd0;
            regvalid_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            bstb_q     <= 1'b0;
            err_q      <= 1'b0;
            regvalid_q <= 1'b0;

            // Parser consumes the byte strobed on the previous cycle; shift_q is still stable.
            if (bstb_q) begin
                case (pst_q)
                    P_SYNC: if (shift_q == SYNC) pst_q <= P_ADDR;
                    P_ADDR: begin
                        addr_hold_q <= shift_q;
                        pst_q       <= P_DATA;
                    end
                    P_DATA: begin
                        regaddr_q  <= addr_hold_q;
                        regdata_q  <= shift_q;
                        regvalid_q <= 1'b1;
                        pst_q      <= P_SYNC;
                    end
                    default: pst_q <= P_SYNC;
                endcase
            end

            case (bst_q)
                IDLE: begin
                    // After a framing error the line must return high before re-arming.
                    if (wait_hi_q) begin
                        if (rx_sync_q) wait_hi_q <= 1'b0;
                    end else if (!rx_sync_q) begin
                        bst_q <= START;
                        cnt_q <= HALF_BIT;
                    end
                end
                START: begin
                    if (cnt_zero) begin
                        if (rx_sync_q) begin
                            bst_q <= IDLE;
                        end else begin
                            bst_q     <= DATA;
                            cnt_q     <= FULL_BIT;
                            bit_idx_q <= 3'd0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                DATA: begin
                    if (cnt_zero) begin
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        cnt_q     <= FULL_BIT;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) bst_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                STOP: begin
                    if (cnt_zero) begin
                        bst_q <= IDLE;
                        if (rx_sync_q) begin
                            bstb_q <= 1'b1;
                        end else begin
                            err_q     <= 1'b1;
                            wait_hi_q <= 1'b1;
                            pst_q     <= P_SYNC;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: bst_q <= IDLE;
            endcase
        end
    end

    assign wr.regaddr  = regaddr_q;
    assign wr.regdata  = regdata_q;
    assign wr.regvalid = regvalid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_uart_regwr.sv
// Directed bench for uart_regwr: serial frames in, write strobes and error
// pulses captured by a monitor and compared against hand-computed values.
module tb_uart_regwr;

    localparam int CLKDIV = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic rx   = 1'b1;
    logic err;

    uart_regwr_if wr_if ();

    uart_regwr #(.CLKDIV(CLKDIV), .SYNC(8'hA5)) dut (
        .clk  (clk),
        .rstn (rstn),
        .rx   (rx),
        .wr   (wr_if),
        .err  (err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: records every write strobe with its cycle stamp and tallies anomalies.
    int         cyc     = 0;
    int         errcnt  = 0;
    int         both    = 0;
    int         dup     = 0;
    int         chg_bad = 0;
    logic       prev_v  = 1'b0;
    logic [7:0] pa      = 8'd0;
    logic [7:0] pd      = 8'd0;
    logic [7:0] wa[$];
    logic [7:0] wd[$];
    int         wc[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rstn) begin
            prev_v <= 1'b0;
            pa     <= wr_if.regaddr;
            pd     <= wr_if.regdata;
        end else begin
            if (wr_if.regvalid) begin
                wa.push_back(wr_if.regaddr);
                wd.push_back(wr_if.regdata);
                wc.push_back(cyc);
            end
            if (err) errcnt <= errcnt + 1;
            if (err && wr_if.regvalid) both <= both + 1;
            if (wr_if.regvalid && prev_v) dup <= dup + 1;
            if (((wr_if.regaddr !== pa) || (wr_if.regdata !== pd)) && !wr_if.regvalid)
                chg_bad <= chg_bad + 1;
            prev_v <= wr_if.regvalid;
            pa     <= wr_if.regaddr;
            pd     <= wr_if.regdata;
        end
    end

    function automatic logic [7:0] get_a(input int k);
        return (wa.size() > k) ? wa[k] : 8'hxx;
    endfunction
    function automatic logic [7:0] get_d(input int k);
        return (wd.size() > k) ? wd[k] : 8'hxx;
    endfunction
    function automatic int get_c(input int k);
        return (wc.size() > k) ? wc[k] : -100000;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends start, 8 data bits LSB first, stop; nbits < 10 truncates the byte.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int nbits);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = f[i];
            idle(CLKDIV);
        end
    endtask

    task automatic send_ok(input logic [7:0] b);
        send_byte(b, 1'b1, 10);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d);
        send_ok(8'hA5);
        send_ok(a);
        send_ok(d);
    endtask

    initial begin
        int e0;

        idle(5);
        #1;
        check_val("rst_regaddr",  32'(wr_if.regaddr),  32'h0);
        check_val("rst_regdata",  32'(wr_if.regdata),  32'h0);
        check_val("rst_regvalid", 32'(wr_if.regvalid), 32'h0);
        check_val("rst_err",      32'(err),            32'h0);
        rstn = 1'b1;
        idle(5);

        // Basic frame
        send_frame(8'h12, 8'h34);
        idle(20);
        check_val("t1_nwrites", 32'(wa.size()), 32'd1);
        check_val("t1_addr",    32'(get_a(0)),  32'h12);
        check_val("t1_data",    32'(get_d(0)),  32'h34);
        check_val("t1_err",     32'(errcnt),    32'd0);

        // Leading junk, SYNC value accepted as data
        send_ok(8'h00);
        send_ok(8'hFF);
        send_frame(8'h07, 8'hA5);
        idle(20);
        check_val("t2_nwrites", 32'(wa.size()), 32'd2);
        check_val("t2_addr",    32'(get_a(1)),  32'h07);
        check_val("t2_data",    32'(get_d(1)),  32'hA5);

        // Framing error on the address byte aborts the frame
        e0 = errcnt;
        send_ok(8'hA5);
        send_byte(8'h44, 1'b0, 10);
        rx = 1'b1;
        idle(2 * CLKDIV);
        send_ok(8'h56);
        send_ok(8'h78);
        idle(20);
        check_val("t3_errpulse", 32'(errcnt),        32'(e0 + 1));
        check_val("t3_nwrites",  32'(wa.size()),     32'd2);
        check_val("t3_hold_a",   32'(wr_if.regaddr), 32'h07);
        check_val("t3_hold_d",   32'(wr_if.regdata), 32'hA5);
        send_frame(8'h01, 8'h02);
        idle(20);
        check_val("t3_nwrites2", 32'(wa.size()), 32'd3);
        check_val("t3_addr",     32'(get_a(2)),  32'h01);
        check_val("t3_data",     32'(get_d(2)),  32'h02);

        // Short low glitch is a false start
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        check_val("t4_glitch_err", 32'(errcnt),    32'(e0 + 1));
        check_val("t4_glitch_nw",  32'(wa.size()), 32'd3);
        send_frame(8'h10, 8'h20);
        idle(20);
        check_val("t4_nwrites", 32'(wa.size()), 32'd4);
        check_val("t4_addr",    32'(get_a(3)),  32'h10);
        check_val("t4_data",    32'(get_d(3)),  32'h20);

        // Back-to-back frames, no idle gap
        send_frame(8'hAA, 8'h55);
        send_frame(8'hBB, 8'h66);
        idle(20);
        check_val("t5_nwrites", 32'(wa.size()),           32'd6);
        check_val("t5_spacing", 32'(get_c(5) - get_c(4)), 32'(30 * CLKDIV));
        check_val("t5_addr0",   32'(get_a(4)),            32'hAA);
        check_val("t5_data0",   32'(get_d(4)),            32'h55);
        check_val("t5_addr1",   32'(get_a(5)),            32'hBB);
        check_val("t5_data1",   32'(get_d(5)),            32'h66);

        // Reset in the middle of a data byte
        send_ok(8'hA5);
        send_ok(8'h99);
        send_byte(8'h77, 1'b1, 5);
        rstn = 1'b0;
        #1;
        check_val("t6_rst_a",   32'(wr_if.regaddr),  32'h0);
        check_val("t6_rst_d",   32'(wr_if.regdata),  32'h0);
        check_val("t6_rst_v",   32'(wr_if.regvalid), 32'h0);
        check_val("t6_rst_err", 32'(err),            32'h0);
        rx = 1'b1;
        idle(10);
        rstn = 1'b1;
        idle(2 * CLKDIV);
        check_val("t6_nospur", 32'(wa.size()), 32'd6);
        send_frame(8'h3C, 8'hC3);
        idle(20);
        check_val("t6_nwrites", 32'(wa.size()), 32'd7);
        check_val("t6_addr",    32'(get_a(6)),  32'h3C);
        check_val("t6_data",    32'(get_d(6)),  32'hC3);

        check_val("err_total",     32'(errcnt),  32'd1);
        check_val("valid_and_err", 32'(both),    32'd0);
        check_val("valid_width",   32'(dup),     32'd0);
        check_val("stray_change",  32'(chg_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_regwr.md
Name: uart_regwr

Overview:
- Serial register-write front end: the producer side of the regaddr/regdata/regvalid write port that the register display and other register consumers sink.
- Receives 8N1 UART bytes from the host and parses 3-byte frames: sync 0xA5, address, data.
- Each complete frame emits exactly one single-cycle write strobe.
- Sits in the clk domain next to the register consumers; its outputs connect directly to their write ports.

Parameters:
- CLKDIV, 434, clk cycles per UART bit (50 MHz / 115200). Legal range 8..65535.
- SYNC, 8'hA5, frame sync byte.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- rx  input  1  UART line, idle high, asynchronous to clk.
- regaddr  output  8  address of the last completed frame.
- regdata  output  8  data of the last completed frame.
- regvalid  output  1  one-cycle write strobe.
- err  output  1  one-cycle framing-error pulse.

Behaviour:
- Reset: regaddr=0, regdata=0, regvalid=0, err=0, bit FSM=IDLE, parser=P_SYNC, synchronizer flops=1.
- Reset is asynchronous and active-low; asserting it mid-byte or mid-frame discards all partial state.
- rx passes through a 2-flop synchronizer; all references to rx below mean the synchronized value.
- Bit FSM states: IDLE, START, DATA, STOP. A 16-bit counter cnt runs the timing.
  - IDLE: on synced rx=0, go to START and load cnt=CLKDIV/2-1 (integer division).
  - START: when cnt reaches 0, sample rx. If 1, it is a false start: return to IDLE with no error. If 0, go to DATA with cnt=CLKDIV-1 and bit index 0.
  - DATA: each time cnt reaches 0, sample one bit, LSB first, into the shift register and reload cnt=CLKDIV-1. After bit 7, go to STOP.
  - STOP: when cnt reaches 0, sample rx.
    - If 1: raise internal byte strobe bstb for 1 cycle, then go to IDLE. A new start bit can be detected on the very next cycle.
    - If 0: framing error. err=1 for 1 cycle, no bstb, parser forced to P_SYNC. Go to IDLE, which waits for rx high before it arms for the next falling edge; a break or held-low line produces exactly one err.
- Parser (advances only on bstb):
  - P_SYNC: byte==SYNC goes to P_ADDR; any other byte is ignored and stays in P_SYNC.
  - P_ADDR: latch byte into an internal address holding register and go to P_DATA. A byte equal to SYNC is accepted as an address; there is no escaping.
  - P_DATA: on the same edge, regaddr<=held address, regdata<=byte, regvalid<=1. Go to P_SYNC.
- Timing of the write strobe:
  - regvalid is high for exactly the one cycle after the clock edge that registered the data byte's bstb.
  - Latency from the data byte's stop-bit sample to regvalid high is 2 clk edges.
- regaddr/regdata hold their values until the next completed frame. They change only together with regvalid.
- A framing error during the address or data byte aborts the frame; regaddr/regdata remain unchanged.
- Back-to-back frames with no idle gap are legal. Minimum spacing between regvalid pulses is 30*CLKDIV cycles.
- regvalid and err are never high in the same cycle.
- Tolerance: sampling at mid-bit must accept a baud mismatch of ±2% over 10 bits.

Test Plan (CLKDIV=16 for simulation):
- Reset, then send bytes A5 12 34 → exactly one regvalid pulse, with regaddr=8'h12 and regdata=8'h34 in that cycle; err never set.
- Send 00 FF A5 07 A5 → the two leading junk bytes are ignored, then one write regaddr=8'h07, regdata=8'hA5.
- Send A5, then an address byte with its stop bit driven low, then 56 78 → one err pulse, no regvalid; regaddr/regdata keep their previous values. A following frame A5 01 02 writes correctly.
- Low glitch of 4 clk on idle rx → no state change, no err. Then send A5 10 20 → normal write.
- Two frames back to back with no gap (A5 AA 55 A5 BB 66) → two regvalid pulses exactly 30*16 clk apart, carrying values AA/55 then BB/66.
- Assert rstn low midway through the data byte of a frame, release, then send A5 3C C3 → outputs are 0 during reset, no spurious regvalid, then a single write 3C/C3.
